circuit_sweep_ctrl: RTL
=======================

# circuit_sweep_ctrl

Sequencer that exhaustively exercises the four-input combinational gate circuit (inputs A, B, C, D; output E) used in the lab datapath. On a start pulse it drives all 16 input vectors in ascending order, waits a settle interval, samples E, and builds the circuit's 16-entry truth table plus a running count of ones. It sits between the lab top level and one instance of the gate circuit, replacing manual switch stimulus.

## Interface
- SETTLE, 1: cycles each vector is held before E is sampled; legal range 1..15.
- EXPECTED, 16'h0301: golden truth table, bit i is E for vector i; default encodes E = ~(B|C) & (A|~D).
- clk  in  1  rising-edge clock.
- rst  in  1  reset, asynchronous and active-high.
- start  in  1  request a sweep; sampled only in IDLE.
- e_in  in  1  E output of the driven circuit.
- vec  out  4  vector to the circuit: vec[3]=A, vec[2]=B, vec[1]=C, vec[0]=D.
- busy  out  1  high in SETTLE and SAMPLE.
- done  out  1  one-cycle pulse when the sweep completes.
- table_out  out  16  captured truth table, bit i = E for vec == i.
- ones  out  5  number of 1 bits captured so far (0..16).
- mismatch  out  1  table_out differs from EXPECTED; valid from done onward.
- mismatch_mask  out  16  table_out ^ EXPECTED, registered at completion.

## Operation
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE: start=1 moves to SETTLE; vec <= 0, settle counter <= 0, table_out <= 0, ones <= 0, mismatch and mismatch_mask <= 0.
- SETTLE: counter increments each cycle; after SETTLE cycles in this state, moves to SAMPLE. vec is stable.
- SAMPLE: one cycle; on the exit edge table_out[vec] <= e_in, ones <= ones + e_in. If vec == 15, moves to DONE, else vec <= vec + 1, counter <= 0, back to SETTLE.
- DONE: done=1 for exactly one cycle, then IDLE. vec holds 15. table_out, ones, and mismatch outputs hold until the next accepted start.
- start in SETTLE, SAMPLE, or DONE is ignored; no queuing. start held high continuously restarts the sweep on the edge leaving IDLE, i.e. one IDLE cycle between sweeps.
- vec never wraps inside a sweep; increment stops at 15.
- ones is 5 bits so an all-ones table (16) does not overflow.
- Reset (any state, including mid-sweep): immediately IDLE, all outputs 0; partial results are discarded.

## Timing
- Reset values: vec=0, busy=0, done=0, table_out=0, ones=0, mismatch=0, mismatch_mask=0.
- Take edge 0 as the edge where start is sampled in IDLE. Vector k is driven from edge k*(SETTLE+1) and captured at edge (k+1)*(SETTLE+1).
- done is high in the cycle after edge 16*(SETTLE+1); with SETTLE=1 this is edge 32.
- busy is high from edge 0 until edge 16*(SETTLE+1); it is low during DONE.
- e_in is a combinational return path: it must settle within SETTLE cycles of a vec change. The block adds no input synchroniser.
- All outputs are registered; there is no combinational path from start or e_in to any output.

## Configuration
- CIRCUIT_SWEEP_CHECK_EN defined: on the edge entering DONE, mismatch_mask <= final table_out ^ EXPECTED and mismatch <= |mismatch_mask; both are therefore valid in the done cycle.
- CIRCUIT_SWEEP_CHECK_EN undefined: mismatch and mismatch_mask are constant 0, the ports remain present, and no compare logic is built.

## Test plan
- Reset, SETTLE=1, correct circuit attached, start pulsed once -> done at edge 32, table_out=16'h0301, ones=3, mismatch=0, busy low after done.
- Model with D stuck at 0 (E = ~(B|C)) -> table_out=16'h0303, ones=4; with the macro defined, mismatch=1 and mismatch_mask=16'h0002.
- SETTLE=3, e_in tied to 1 -> done at edge 64, table_out=16'hFFFF, ones=16 with no overflow; vec is checked to hold each value for 4 cycles.
- start pulsed again at edge 10 and during the done cycle -> both ignored, exactly one done pulse, results unchanged; start held high -> second sweep begins after one IDLE cycle.
- rst asserted asynchronously mid-cycle at edge 20 -> all outputs 0 immediately; after release, a new start produces a complete, correct table.
- Macro undefined with a mismatching model -> mismatch=0 and mismatch_mask=0 throughout, while table_out still shows the faulty table.

Source files
------------

// File: rtl/circuit_sweep_ctrl.sv
// circuit_sweep_ctrl
//
// Drives all 16 input vectors of a four-input gate circuit in ascending
// order. Each vector is held for SETTLE cycles and then E is sampled for one
// cycle. The block builds the 16-entry truth table and a running count of
// ones. Results hold until the next accepted start.
//
// Optional feature: define CIRCUIT_SWEEP_CHECK_EN to compare the captured
// table against EXPECTED on completion. When the macro is undefined,
// mismatch and mismatch_mask are tied to 0.
//
// Parameters
//   SETTLE         cycles each vector is held before E is sampled (1..15)
//   EXPECTED       golden truth table, bit i = E for vector i
// Ports
//   clk            rising-edge clock
//   rst            asynchronous active-high reset
//   start          sweep request, sampled only in idle
//   e_in           E output of the driven circuit
//   vec            vector to the circuit {A, B, C, D}
//   busy           high while vectors are being settled and sampled
//   done           one-cycle completion pulse
//   table_out      captured truth table
//   ones           number of ones captured so far (0..16)
//   mismatch       table_out differs from EXPECTED, valid from done onward
//   mismatch_mask  table_out ^ EXPECTED, registered at completion
module circuit_sweep_ctrl #(
  parameter int unsigned SETTLE   = 1,
  parameter logic [15:0] EXPECTED = 16'h0301
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        e_in,
  output logic [3:0]  vec,
  output logic        busy,
  output logic        done,
  output logic [15:0] table_out,
  output logic [4:0]  ones,
  output logic        mismatch,
  output logic [15:0] mismatch_mask
);

  localparam logic [3:0] SettleLast = 4'(SETTLE - 1);

  typedef enum logic [1:0] {StIdle, StSettle, StSample, StDone} state_e;

  state_e      state;
  logic [3:0]  cnt;
  logic [15:0] table_cap;

  // Table as it will look after the current sample is written. This lets the
  // completion compare include the final bit in the same edge.
  always_comb begin
    table_cap      = table_out;
    table_cap[vec] = e_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= StIdle;
      vec           <= '0;
      cnt           <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      table_out     <= '0;
      ones          <= '0;
`ifdef CIRCUIT_SWEEP_CHECK_EN
      mismatch      <= 1'b0;
      mismatch_mask <= '0;
`endif
    end else begin
      unique case (state)
        StIdle: begin
          if (start) begin
            state         <= StSettle;
            vec           <= '0;
            cnt           <= '0;
            busy          <= 1'b1;
            table_out     <= '0;
            ones          <= '0;
`ifdef CIRCUIT_SWEEP_CHECK_EN
            mismatch      <= 1'b0;
            mismatch_mask <= '0;
`endif
          end
        end
        StSettle: begin
          if (cnt == SettleLast) begin
            state <= StSample;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        StSample: begin
          table_out <= table_cap;
          ones      <= ones + {4'd0, e_in};
          if (vec == 4'hf) begin
            // vec is left at 15; it never wraps inside a sweep.
            state         <= StDone;
            busy          <= 1'b0;
            done          <= 1'b1;
`ifdef CIRCUIT_SWEEP_CHECK_EN
            mismatch_mask <= table_cap ^ EXPECTED;
            mismatch      <= |(table_cap ^ EXPECTED);
`endif
          end else begin
            state <= StSettle;
            vec   <= vec + 4'd1;
            cnt   <= '0;
          end
        end
        StDone: begin
          done  <= 1'b0;
          state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

`ifndef CIRCUIT_SWEEP_CHECK_EN
  assign mismatch      = 1'b0;
  assign mismatch_mask = '0;
`endif

endmodule
